// File: rtl/mdu_unit_if.sv
// Bus between the E-stage datapath and the multiply/divide unit.
// Start/Busy go to the stall unit; Out is the mfhi/mflo read value.
interface mdu_unit_if;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Start;
  logic        Busy;
  logic [31:0] Out;

  modport master (output MDUOp, A, B, input Start, Busy, Out);
  modport slave  (input MDUOp, A, B, output Start, Busy, Out);
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed on the
// accepting edge into HI_t/LO_t and committed to HI/LO when the busy countdown ends.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus,
  output logic       state_dbg
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [31:0]        hi, lo, hi_t, lo_t;
  logic [CNT_W-1:0]   cnt;
  logic               is_md, is_mult, is_signed;
  logic [63:0]        prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [31:0]        a_mag, b_mag, b_safe, q_mag, r_mag;
  logic [31:0]        res_hi, res_lo;

  assign is_md     = (bus.MDUOp >= 4'd1) && (bus.MDUOp <= 4'd4);
  assign is_mult   = (bus.MDUOp == 4'd1) || (bus.MDUOp == 4'd2);
  assign is_signed = (bus.MDUOp == 4'd1) || (bus.MDUOp == 4'd3);

  // Handshake: Start is a one-cycle accept strobe (md op present and not Busy);
  // Busy is high for exactly the configured length afterwards. The stall unit
  // treats Start|Busy as "MDU occupied", so there is no valid/ready back-pressure.
  assign bus.Start = is_md && (state_q == S_IDLE);
  assign bus.Busy  = (state_q == S_RUN);
  assign state_dbg = state_q;

  always_comb begin
    bus.Out = 32'd0;
    if (bus.MDUOp == 4'd5) bus.Out = hi;
    else if (bus.MDUOp == 4'd6) bus.Out = lo;
  end

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Division on magnitudes avoids signed-overflow corner cases; 0x80000000/-1
  // naturally yields quotient 0x80000000, remainder 0.
  assign a_neg  = is_signed && bus.A[31];
  assign b_neg  = is_signed && bus.B[31];
  assign a_mag  = a_neg ? (32'd0 - bus.A) : bus.A;
  assign b_mag  = b_neg ? (32'd0 - bus.B) : bus.B;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    if (is_mult) begin
      res_hi = is_signed ? prod_s[63:32] : prod_u[63:32];
      res_lo = is_signed ? prod_s[31:0]  : prod_u[31:0];
    end else if (bus.B != 32'd0) begin
      res_lo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      res_hi = a_neg ? (32'd0 - r_mag) : r_mag;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.Start) state_d = S_RUN;
      S_RUN:  if (cnt == CNT_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi      <= 32'd0;
      lo      <= 32'd0;
      hi_t    <= 32'd0;
      lo_t    <= 32'd0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (bus.Start) begin
          hi_t <= res_hi;
          lo_t <= res_lo;
          cnt  <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (bus.MDUOp == 4'd7) begin
          hi <= bus.A;
        end else if (bus.MDUOp == 4'd8) begin
          lo <= bus.A;
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi <= hi_t;
          lo <= lo_t;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed corner cases plus random md ops, with mfhi/mflo
// reads checked by a queue-based scoreboard against an arithmetic model.
module tb_mdu_unit;

  logic clk = 1'b0;
  logic reset;
  logic state_dbg;

  mdu_unit_if bus();

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hi_m, lo_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drivers act just after the falling edge; this leaves the low phase for checks.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Monitor: whenever a read op is presented, pop and compare Out.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (bus.MDUOp == 4'd5 || bus.MDUOp == 4'd6) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=%h expected=none", bus.Out);
        end else begin
          check("out_read", bus.Out, exp_q.pop_front());
        end
      end
    end
  end

  // Reference model: plain 64-bit integer arithmetic on the architectural result.
  task automatic model_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd2: begin up = ua * ub; p = up; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd3: if (b != 0) begin
        sq = sa / sb; sr = sa % sb;
        p = sq; lo_m = p[31:0];
        p = sr; hi_m = p[31:0];
      end
      4'd4: if (b != 0) begin
        p = ua / ub; lo_m = p[31:0];
        p = ua % ub; hi_m = p[31:0];
      end
      default: ;
    endcase
  endtask

  task automatic read_hi();
    exp_q.push_back(hi_m);
    bus.MDUOp = 4'd5;
    next_cycle();
    bus.MDUOp = 4'd0;
  endtask

  task automatic read_lo();
    exp_q.push_back(lo_m);
    bus.MDUOp = 4'd6;
    next_cycle();
    bus.MDUOp = 4'd0;
  endtask

  task automatic write_hilo(input bit to_hi, input logic [31:0] v);
    bus.MDUOp = to_hi ? 4'd7 : 4'd8;
    bus.A     = v;
    next_cycle();
    bus.MDUOp = 4'd0;
    if (to_hi) hi_m = v; else lo_m = v;
  endtask

  // Issue one md op; optionally throw ignored ops at the unit while it is busy.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject);
    int n;
    int cnt;
    bit done;
    n    = (op <= 4'd2) ? 5 : 10;
    cnt  = 0;
    done = 1'b0;
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    #1;
    check("start_on_issue", {31'd0, bus.Start}, 32'd1);
    check("busy_on_issue", {31'd0, bus.Busy}, 32'd0);
    next_cycle();
    bus.MDUOp = 4'd0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (bus.Busy) cnt++;
      else done = 1'b1;
      if (!done) begin
        if (inject) begin
          case (cnt)
            1: begin
              bus.MDUOp = 4'd1; bus.A = $urandom; bus.B = $urandom;
              #1;
              check("start_blocked", {31'd0, bus.Start}, 32'd0);
            end
            2: begin bus.MDUOp = 4'd7; bus.A = $urandom; end
            3: begin exp_q.push_back(hi_m); bus.MDUOp = 4'd5; end
            default: bus.MDUOp = 4'd0;
          endcase
        end
        next_cycle();
      end
    end
    bus.MDUOp = 4'd0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout actual=stuck expected=%0d", n);
    end else begin
      check("busy_len", cnt, n);
    end
    model_md(op, a, b);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset     = 1'b1;
    bus.MDUOp = 4'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    hi_m      = 32'd0;
    lo_m      = 32'd0;
    @(negedge clk);
    #1;
    repeat (3) next_cycle();
    reset = 1'b0;
    check("reset_busy", {31'd0, bus.Busy}, 32'd0);
    check("reset_start", {31'd0, bus.Start}, 32'd0);
    check("reset_out", bus.Out, 32'd0);
    read_hi();
    read_lo();

    issue(4'd1, 32'hFFFFFFFD, 32'd5, 1'b1);
    read_hi(); read_lo();
    issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    read_hi(); read_lo();
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    read_hi(); read_lo();
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    read_hi(); read_lo();
    issue(4'd4, 32'hFFFFFFF9, 32'd2, 1'b0);
    read_hi(); read_lo();

    write_hilo(1'b1, 32'h12345678);
    read_hi();
    write_hilo(1'b0, 32'h9ABCDEF0);
    issue(4'd3, 32'h00000064, 32'd0, 1'b1);
    read_hi(); read_lo();

    // Back-to-back: the div is accepted in the first cycle after the mult drops Busy.
    issue(4'd1, 32'h00012345, 32'hFFFF0001, 1'b0);
    issue(4'd3, 32'h7FFFFFFF, 32'hFFFFFFFD, 1'b0);
    read_hi(); read_lo();

    // Reset during busy cycle 3 discards the in-flight mult.
    bus.MDUOp = 4'd1; bus.A = 32'h00000007; bus.B = 32'h00000009;
    next_cycle();
    bus.MDUOp = 4'd0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    check("busy_after_reset", {31'd0, bus.Busy}, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    read_hi(); read_lo();

    for (int k = 0; k < 20; k++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) write_hilo($urandom_range(0, 1) == 1, $urandom);
      issue(op, a, b, $urandom_range(0, 1) == 1);
      read_hi();
      read_lo();
    end

    next_cycle();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
